// File: rtl/if_stage.sv
// Instruction fetch: credit-limited request issue, in-order response capture into a
// small buffer, and redirect handling that drops stale in-flight responses.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e                   r_state;
  logic [31:0]              r_fetch_pc;
  logic [31:0]              r_rsp_pc;
  logic [CW-1:0]            r_outstanding;
  logic [CW-1:0]            r_drop_cnt;
  logic [CW-1:0]            r_count;
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [DEPTH-1:0][31:0]   r_buf_data;
  logic [DEPTH-1:0][31:0]   r_buf_pc;

  logic          w_req_fire;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW:0]   w_credits_used;
  logic [CW-1:0] w_out_nxt;
  logic [31:0]   w_redir_pc;

  // Buffered entries count against the credit so a push can never find the buffer full.
  assign w_credits_used = {1'b0, r_outstanding} + {1'b0, r_count};
  assign imem_req_valid = rst_n & ~redirect_valid & (w_credits_used < (CW+1)'(DEPTH));
  assign imem_addr      = r_fetch_pc;

  assign instr_valid = (r_count != '0) & ~redirect_valid;
  assign Instr       = r_buf_data[r_rd_ptr];
  assign instr_pc    = r_buf_pc[r_rd_ptr];

  assign w_req_fire = imem_req_valid & imem_req_ready;
  assign w_pop      = instr_valid & instr_ready;
  assign w_drop     = imem_rsp_valid & (r_state == S_FLUSH);
  assign w_push     = imem_rsp_valid & (r_state == S_RUN);
  assign w_out_nxt  = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
  assign w_redir_pc = redirect_pc & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_buf_data    <= '0;
      r_buf_pc      <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (redirect_valid) begin
        // No request fires during a redirect, so w_out_nxt is exactly what is still in flight.
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_drop_cnt <= w_out_nxt;
        r_state    <= (w_out_nxt != '0) ? S_FLUSH : S_RUN;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
          if (r_drop_cnt == CW'(1)) r_state <= S_RUN;
        end
        if (w_push) begin
          r_buf_data[r_wr_ptr] <= imem_rsp_data;
          r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
          r_wr_ptr             <= r_wr_ptr + PW'(1);
          r_rsp_pc             <= r_rsp_pc + 32'd4;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order 1-cycle instruction memory that can be
// held to keep requests in flight.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] Instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  bit mem_hold = 1'b0;
  logic [31:0] mq[$];

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .Instr(Instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: a request accepted at edge N is presented after N and consumed at N+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_addr);
      if (!mem_hold && mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mdata(mq[0]);
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_reset(input bit hold);
    step();
    rst_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b1;
    mem_hold = hold;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Accept the next instruction; n is the number of idle cycles waited first.
  task automatic get_instr(output logic [31:0] pc, output logic [31:0] d, output bit ok,
                           output int n);
    ok = 1'b0; pc = 'x; d = 'x; n = 0;
    instr_ready = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (instr_valid) begin
        pc = instr_pc; d = Instr; ok = 1'b1; n = i;
      end
      step();
    end
  endtask

  task automatic expect_instr(input string name, input logic [31:0] exp_pc);
    logic [31:0] pc, d; bit ok; int n;
    get_instr(pc, d, ok, n);
    checks++;
    if (!ok || pc !== exp_pc || d !== mdata(exp_pc)) begin
      failures++;
      $display("FAIL %s got pc=%h data=%h ok=%0d exp pc=%h data=%h", name, pc, d, ok, exp_pc,
               mdata(exp_pc));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0;
    #12;
    checks++;
    if ({imem_req_valid, instr_valid} !== 2'b00 || Instr !== '0 || instr_pc !== '0 || imem_addr !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b iv=%b instr=%h pc=%h addr=%h exp all 0",
               imem_req_valid, instr_valid, Instr, instr_pc, imem_addr);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req got req=%b addr=%h exp 1 00000000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_req_stall();
    step(); step(); step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL req_stall got req=%b addr=%h exp 1 00000000", imem_req_valid, imem_addr);
    end
    imem_req_ready = 1'b1;
    expect_instr("stall_release", 32'h0);
  endtask

  task automatic test_streaming();
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) expect_instr($sformatf("stream%0d", i), 32'(i * 4));
  endtask

  task automatic test_backpressure();
    logic [31:0] pc, d; bit ok; int n; bit stable;
    do_reset(1'b0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 1 && (instr_valid !== 1'b1 || instr_pc !== 32'h0 || Instr !== mdata(32'h0))) stable = 1'b0;
    end
    checks++;
    if (!stable) begin failures++; $display("FAIL bp_head_stable got 0 exp 1"); end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL bp_req_blocked got req=%b exp 0", imem_req_valid);
    end
    expect_instr("bp_first", 32'h0);
    get_instr(pc, d, ok, n);
    checks++;
    if (!ok || pc !== 32'h4 || n !== 0) begin
      failures++; $display("FAIL bp_second got pc=%h wait=%0d exp pc=00000004 wait=0", pc, n);
    end
    expect_instr("bp_third", 32'h8);
  endtask

  task automatic test_redirect_inflight();
    do_reset(1'b1);
    step(); step(); step();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL credits_full got req=%b exp 0", imem_req_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0; mem_hold = 1'b0;
    checks++;
    if (imem_addr !== 32'h100) begin
      failures++; $display("FAIL redir_addr got %h exp 00000100", imem_addr);
    end
    expect_instr("redir_drop2", 32'h100);
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'h100) begin
      failures++; $display("FAIL misalign_addr got %h exp 00000100", imem_addr);
    end
    expect_instr("misalign_pc", 32'h100);
  endtask

  task automatic test_redirect_rsp_pop();
    do_reset(1'b1);
    step(); step();
    mem_hold = 1'b0;
    step(); step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_pop_setup got iv=%b pc=%h rsp=%b exp 1 00000000 1", instr_valid, instr_pc,
               imem_rsp_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_masks got iv=%b req=%b exp 0 0", instr_valid, imem_req_valid);
    end
    step();
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL redir_flush got iv=%b exp 0", instr_valid);
    end
    expect_instr("rsp_pop_target", 32'h200);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    expect_instr("wrap_top", 32'hFFFF_FFFC);
    expect_instr("wrap_zero", 32'h0);
  endtask

  task automatic test_reset_mid();
    expect_instr("pre_reset", 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, instr_valid} !== 2'b00 || Instr !== '0 || instr_pc !== '0 || imem_addr !== '0) begin
      failures++;
      $display("FAIL mid_reset got req=%b iv=%b instr=%h pc=%h addr=%h exp all 0",
               imem_req_valid, instr_valid, Instr, instr_pc, imem_addr);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart got req=%b addr=%h iv=%b exp 1 00000000 0", imem_req_valid, imem_addr,
               instr_valid);
    end
    expect_instr("restart0", 32'h0);
    expect_instr("restart1", 32'h4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_req_stall();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_misaligned();
    test_redirect_rsp_pop();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
